// File: rtl/counter_pkg.sv
// Shared definitions for the counter start/done handshake blocks.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CMPL  = 2'd3
  } state_t;

  localparam int unsigned DEF_DWIDTH     = 7;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_TMO_WIDTH  = 16;
  localparam int unsigned DEF_TMO_CYCLES = 1000;

endpackage

// File: rtl/count_job_issuer_if.sv
// Job intake, counter-controller and completion signals of count_job_issuer.
interface count_job_issuer_if #(
  parameter int unsigned DWIDTH = counter_pkg::DEF_DWIDTH
);

  logic              job_valid_i;
  logic              job_ready_o;
  logic [DWIDTH-1:0] job_val_i;
  logic              start_o;
  logic [DWIDTH-1:0] cnt_val_o;
  logic              run_i;
  logic              done_i;
  logic              cmpl_valid_o;
  logic              cmpl_ready_i;
  logic [DWIDTH-1:0] cmpl_val_o;
  logic              cmpl_err_o;

  modport master (
    input  job_valid_i,
    input  job_val_i,
    input  run_i,
    input  done_i,
    input  cmpl_ready_i,
    output job_ready_o,
    output start_o,
    output cnt_val_o,
    output cmpl_valid_o,
    output cmpl_val_o,
    output cmpl_err_o
  );

  modport slave (
    output job_valid_i,
    output job_val_i,
    output run_i,
    output done_i,
    output cmpl_ready_i,
    input  job_ready_o,
    input  start_o,
    input  cnt_val_o,
    input  cmpl_valid_o,
    input  cmpl_val_o,
    input  cmpl_err_o
  );

endinterface

// File: rtl/count_job_fifo.sv
// Synchronous job FIFO; pointers carry an extra wrap bit to tell full from empty.
module count_job_fifo #(
  parameter int unsigned DWIDTH = counter_pkg::DEF_DWIDTH,
  parameter int unsigned DEPTH  = counter_pkg::DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/count_job_issuer.sv
// Buffers count jobs, issues them one at a time to the counter controller and
// returns an in-order completion record per job, with a watchdog on done.
module count_job_issuer
  import counter_pkg::*;
#(
  parameter int unsigned DWIDTH     = DEF_DWIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned TMO_WIDTH  = DEF_TMO_WIDTH,
  parameter int unsigned TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  count_job_issuer_if.master bus,
  output logic               busy_o
);

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);

  state_t                state;
  logic [TMO_WIDTH-1:0]  wdog;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DWIDTH-1:0]     fifo_head;
  logic                  head_zero;

  assign head_zero       = (fifo_head == '0);
  assign fifo_push       = bus.job_valid_i && !fifo_full;
  // Zero counts are popped straight from IDLE; real jobs leave the FIFO in ISSUE.
  assign fifo_pop        = (state == ISSUE) ||
                           ((state == IDLE) && !fifo_empty && head_zero);
  assign bus.job_ready_o = !fifo_full;
  assign busy_o          = (state != IDLE) || !fifo_empty;

  count_job_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.job_val_i),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wdog             <= '0;
      bus.start_o      <= 1'b0;
      bus.cnt_val_o    <= '0;
      bus.cmpl_valid_o <= 1'b0;
      bus.cmpl_val_o   <= '0;
      bus.cmpl_err_o   <= 1'b0;
    end else begin
      bus.start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_zero) begin
              state            <= CMPL;
              bus.cmpl_valid_o <= 1'b1;
              bus.cmpl_val_o   <= '0;
              bus.cmpl_err_o   <= 1'b1;
            end else begin
              state         <= ISSUE;
              bus.start_o   <= 1'b1;
              bus.cnt_val_o <= fifo_head;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          wdog  <= '0;
        end
        WAIT: begin
          // done_i takes priority over a timeout landing in the same cycle
          if (bus.done_i) begin
            state            <= CMPL;
            bus.cmpl_valid_o <= 1'b1;
            bus.cmpl_val_o   <= bus.cnt_val_o;
            bus.cmpl_err_o   <= 1'b0;
          end else if (wdog == TMO_LAST) begin
            state            <= CMPL;
            bus.cmpl_valid_o <= 1'b1;
            bus.cmpl_val_o   <= bus.cnt_val_o;
            bus.cmpl_err_o   <= 1'b1;
          end else if (wdog != '1) begin
            wdog <= wdog + TMO_WIDTH'(1);
          end
        end
        CMPL: begin
          if (bus.cmpl_ready_i) begin
            state            <= IDLE;
            bus.cmpl_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_job_issuer.sv
// Directed bench for count_job_issuer: vector table plus hand-written sequences.
module tb_count_job_issuer;

  localparam int unsigned DW  = 7;
  localparam int unsigned TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_o;
  int   checks = 0;
  int   errors = 0;

  count_job_issuer_if #(.DWIDTH(DW)) bus ();

  count_job_issuer #(
    .DWIDTH     (DW),
    .DEPTH      (4),
    .TMO_WIDTH  (16),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  // Cycle n (relative to the push in cycle 0): done_at = cycle in which done_i
  // pulses (0 = never), exp_cmpl = first cycle with cmpl_valid_o=1.
  typedef struct {
    logic [DW-1:0] val;
    int            done_at;
    logic          exp_start;
    int            exp_cmpl;
    logic [DW-1:0] exp_cval;
    logic          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int n         = 0;
    int starts    = 0;
    int start_cyc = -1;
    int cmpl_cyc  = -1;
    logic [DW-1:0] cv = '0;
    bus.job_valid_i  = 1'b1;
    bus.job_val_i    = v.val;
    bus.cmpl_ready_i = 1'b0;
    while (cmpl_cyc < 0 && n < 60) begin
      bus.done_i = (v.done_at != 0) && (n == v.done_at);
      bus.run_i  = n[0];
      step();
      n++;
      bus.job_valid_i = 1'b0;
      if (n == 1) chk($sformatf("v%0d_busy", idx), busy_o, 1);
      if (bus.start_o) begin
        starts++;
        if (start_cyc < 0) start_cyc = n;
        cv = bus.cnt_val_o;
      end
      if (bus.cmpl_valid_o) cmpl_cyc = n;
    end
    bus.done_i = 1'b0;
    chk($sformatf("v%0d_start_count", idx), starts, v.exp_start ? 1 : 0);
    if (v.exp_start) begin
      chk($sformatf("v%0d_start_cycle", idx), start_cyc, 2);
      chk($sformatf("v%0d_cnt_val", idx), cv, v.val);
    end
    chk($sformatf("v%0d_cmpl_cycle", idx), cmpl_cyc, v.exp_cmpl);
    chk($sformatf("v%0d_cmpl_val", idx), bus.cmpl_val_o, v.exp_cval);
    chk($sformatf("v%0d_cmpl_err", idx), bus.cmpl_err_o, v.exp_err);
    bus.cmpl_ready_i = 1'b1;
    step();
    bus.cmpl_ready_i = 1'b0;
    chk($sformatf("v%0d_cmpl_drop", idx), bus.cmpl_valid_o, 0);
    chk($sformatf("v%0d_idle", idx), busy_o, 0);
  endtask

  initial begin
    logic [DW-1:0] jobs[5];
    int pushed;
    int got;
    int done_at;
    int seen;
    logic accept;

    bus.job_valid_i  = 1'b0;
    bus.job_val_i    = '0;
    bus.run_i        = 1'b0;
    bus.done_i       = 1'b0;
    bus.cmpl_ready_i = 1'b0;

    vecs[0] = '{7'd5,   7,  1'b1, 8,  7'd5,   1'b0};
    vecs[1] = '{7'd127, 3,  1'b1, 4,  7'd127, 1'b0};
    vecs[2] = '{7'd1,   21, 1'b1, 22, 7'd1,   1'b0};
    vecs[3] = '{7'd6,   22, 1'b1, 23, 7'd6,   1'b0};
    vecs[4] = '{7'd9,   0,  1'b1, 23, 7'd9,   1'b1};
    vecs[5] = '{7'd4,   2,  1'b1, 23, 7'd4,   1'b1};
    vecs[6] = '{7'd0,   0,  1'b0, 2,  7'd0,   1'b1};
    vecs[7] = '{7'd0,   1,  1'b0, 2,  7'd0,   1'b1};
    vecs[8] = '{7'd64,  10, 1'b1, 11, 7'd64,  1'b0};

    // Reset values
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_start", bus.start_o, 0);
    chk("rst_cnt_val", bus.cnt_val_o, 0);
    chk("rst_cmpl_valid", bus.cmpl_valid_o, 0);
    chk("rst_cmpl_val", bus.cmpl_val_o, 0);
    chk("rst_cmpl_err", bus.cmpl_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_job_ready", bus.job_ready_o, 1);

    for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

    // Back-to-back jobs into DEPTH=4; controller answers 3 cycles after start
    jobs    = '{7'd3, 7'd7, 7'd2, 7'd9, 7'd4};
    pushed  = 0;
    got     = 0;
    done_at = -1;
    bus.cmpl_ready_i = 1'b1;
    for (int n = 0; n < 200 && got < 5; n++) begin
      bus.job_valid_i = (pushed < 5);
      bus.job_val_i   = (pushed < 5) ? jobs[pushed] : '0;
      bus.done_i      = (n == done_at);
      if (n >= 5 && n <= 8) chk($sformatf("b2b_ready_full_c%0d", n), bus.job_ready_o, 0);
      if (n == 9) chk("b2b_ready_after_pop", bus.job_ready_o, 1);
      if (n == 2) chk("b2b_first_start", bus.start_o, 1);
      if (bus.start_o) done_at = n + 3;
      if (bus.cmpl_valid_o) begin
        chk($sformatf("b2b_cmpl_val%0d", got), bus.cmpl_val_o, jobs[got]);
        chk($sformatf("b2b_cmpl_err%0d", got), bus.cmpl_err_o, 0);
        got++;
      end
      accept = bus.job_valid_i && bus.job_ready_o;
      step();
      if (accept) pushed++;
    end
    bus.job_valid_i  = 1'b0;
    bus.done_i       = 1'b0;
    bus.cmpl_ready_i = 1'b0;
    chk("b2b_pushed", pushed, 5);
    chk("b2b_completions", got, 5);
    step();
    chk("b2b_idle", busy_o, 0);

    // Back-pressure on the completion port with stray done_i pulses
    bus.job_valid_i = 1'b1;
    bus.job_val_i   = 7'd11;
    step();                              // cycle 1
    bus.job_val_i   = 7'd12;
    step();                              // cycle 2: start for 11
    bus.job_valid_i = 1'b0;
    chk("bp_start11", bus.start_o, 1);
    step();                              // cycle 3: WAIT
    bus.done_i = 1'b1;
    step();                              // cycle 4: CMPL
    for (int n = 4; n < 14; n++) begin
      bus.done_i = 1'b1;
      chk($sformatf("bp_valid_c%0d", n), bus.cmpl_valid_o, 1);
      chk($sformatf("bp_val_c%0d", n), bus.cmpl_val_o, 11);
      chk($sformatf("bp_err_c%0d", n), bus.cmpl_err_o, 0);
      chk($sformatf("bp_nostart_c%0d", n), bus.start_o, 0);
      step();
    end
    bus.done_i       = 1'b0;
    bus.cmpl_ready_i = 1'b1;             // cycle 14: handshake
    step();                              // cycle 15: IDLE
    bus.cmpl_ready_i = 1'b0;
    chk("bp_released", bus.cmpl_valid_o, 0);
    chk("bp_no_early_start", bus.start_o, 0);
    bus.done_i = 1'b1;                   // done in IDLE, ignored
    step();                              // cycle 16: start for 12
    bus.done_i = 1'b0;
    chk("bp_start12", bus.start_o, 1);
    chk("bp_cnt12", bus.cnt_val_o, 12);
    chk("bp_no_cmpl", bus.cmpl_valid_o, 0);
    step();                              // cycle 17
    step();                              // cycle 18
    chk("bp_still_wait", bus.cmpl_valid_o, 0);
    bus.done_i = 1'b1;
    step();                              // cycle 19
    bus.done_i = 1'b0;
    chk("bp_cmpl12_valid", bus.cmpl_valid_o, 1);
    chk("bp_cmpl12_val", bus.cmpl_val_o, 12);
    chk("bp_cmpl12_err", bus.cmpl_err_o, 0);
    bus.cmpl_ready_i = 1'b1;
    step();
    bus.cmpl_ready_i = 1'b0;

    // Reset while WAITing with two jobs still queued
    bus.job_valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.job_val_i = DW'(20 + n);
      step();
    end
    bus.job_valid_i = 1'b0;              // cycle 3: WAIT for job 20
    step();                              // cycle 4
    chk("mid_busy", busy_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_start", bus.start_o, 0);
    chk("mid_rst_cnt_val", bus.cnt_val_o, 0);
    chk("mid_rst_cmpl_valid", bus.cmpl_valid_o, 0);
    chk("mid_rst_cmpl_val", bus.cmpl_val_o, 0);
    chk("mid_rst_cmpl_err", bus.cmpl_err_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_job_ready", bus.job_ready_o, 1);
    seen = 0;
    bus.cmpl_ready_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      bus.done_i = (n == 3);
      step();
      if (bus.start_o || bus.cmpl_valid_o) seen++;
    end
    bus.done_i       = 1'b0;
    bus.cmpl_ready_i = 1'b0;
    chk("mid_rst_no_activity", seen, 0);
    chk("mid_rst_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
